// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types for the cache refill arbiter.
// State/owner encodings and block address helpers.
package mem_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } owner_t;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  function automatic logic [15:0] word_addr(
    input logic [15:0] base,
    input logic [2:0]  idx
  );
    return base | {12'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Word counter for a block refill.
// Flags the last word of the block.
module fill_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == W'(LAST));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares main memory between I-cache and D-cache:
// block refills plus write-through stores.
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_wdata,
  output logic              dc_wr_ack,
  output logic              ic_fsm_busy,
  output logic              dc_fsm_busy,
  output logic              ic_write_data_array,
  output logic              dc_write_data_array,
  output logic              ic_write_tag_array,
  output logic              dc_write_tag_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [ADDR_W-1:0] fill_data,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  input  logic [ADDR_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  localparam int CNT_W = $clog2(WORDS);

  state_t            state, state_nx;
  owner_t            owner, last_grant, win;
  logic [ADDR_W-1:0] base;
  logic [1:0]        mask;
  logic              grant;
  logic              req_ic, req_dc;
  logic              busy, wda, tag;
  logic              iss_inc, rcv_inc;
  logic              iss_last, rcv_last;
  logic [CNT_W-1:0]  iss_cnt, rcv_cnt;

  fill_counter #(.W(CNT_W), .LAST(WORDS - 1)) u_iss (
    .clk  (clk),
    .rst  (rst),
    .inc  (iss_inc),
    .clr  (grant),
    .cnt  (iss_cnt),
    .last (iss_last)
  );

  fill_counter #(.W(CNT_W), .LAST(WORDS - 1)) u_rcv (
    .clk  (clk),
    .rst  (rst),
    .inc  (rcv_inc),
    .clr  (grant),
    .cnt  (rcv_cnt),
    .last (rcv_last)
  );

  assign req_ic = ic_miss & ~mask[0];
  assign req_dc = dc_miss & ~mask[1];

  always_comb begin
    state_nx     = state;
    grant        = 1'b0;
    win          = IC;
    busy         = 1'b0;
    wda          = 1'b0;
    tag          = 1'b0;
    iss_inc      = 1'b0;
    rcv_inc      = 1'b0;
    dc_wr_ack    = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    fill_address = '0;
    fill_data    = '0;
    unique case (state)
      IDLE: begin
        if (dc_wr && rst) begin
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = dc_addr;
          mem_data_in = dc_wdata;
          dc_wr_ack   = 1'b1;
        end else if (req_ic || req_dc) begin
          grant    = 1'b1;
          state_nx = FILL;
          unique case (1'b1)
            req_ic && req_dc: win = owner_t'(~last_grant);
            req_dc && !req_ic: win = DC;
            req_ic && !req_dc: win = IC;
          endcase
        end
      end
      FILL: begin
        busy       = 1'b1;
        iss_inc    = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = word_addr(base, iss_cnt);
        if (iss_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (mem_data_valid && rcv_last) state_nx = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        tag          = 1'b1;
        fill_address = base;
        state_nx     = IDLE;
      end
    endcase
    // Returned words land while issuing and while draining
    if (state == FILL || state == DRAIN) begin
      fill_address = word_addr(base, rcv_cnt);
      if (mem_data_valid) begin
        wda       = 1'b1;
        rcv_inc   = 1'b1;
        fill_data = mem_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= IC;
      last_grant <= IC;
      base       <= '0;
      mask       <= '0;
    end else begin
      state <= state_nx;
      mask  <= '0;
      if (grant) begin
        owner      <= win;
        last_grant <= win;
        base       <= (win == DC ? dc_addr : ic_addr) & BLOCK_MASK;
      end
      // Finished cache's miss is still up for one cycle
      if (state == DONE) mask <= (owner == DC) ? 2'b10 : 2'b01;
    end
  end

  assign ic_fsm_busy         = busy & (owner == IC);
  assign dc_fsm_busy         = busy & (owner == DC);
  assign ic_write_data_array = wda  & (owner == IC);
  assign dc_write_data_array = wda  & (owner == DC);
  assign ic_write_tag_array  = tag  & (owner == IC);
  assign dc_write_tag_array  = tag  & (owner == DC);

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single pipelined main memory between the instruction cache and the data cache.
- On a cache miss it fetches the whole 8-word block for that cache and writes it into the data array. It then raises the tag write strobe for the refill.
- It also issues write-through stores from the data cache.
- It sits between both cache instances and the 4-cycle memory model, and drives each cache's fsm_busy, memory_address, memory_data_out, write_data_array and write_tag_array.

Parameters:
- ADDR_W, 16, address and data width in bits.
- WORDS, 8, 16-bit words per cache block (block = 16 bytes).
- MEM_LAT, 4, cycles from mem_enable to mem_data_valid for a read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ic_miss  in  1  I-cache read miss.
- ic_addr  in  16  I-cache miss address.
- dc_miss  in  1  D-cache read miss (stores never raise it; no write-allocate).
- dc_addr  in  16  D-cache miss or store address.
- dc_wr  in  1  D-cache store request.
- dc_wdata  in  16  store data.
- dc_wr_ack  out  1  one-cycle pulse when the store is issued to memory.
- ic_fsm_busy, dc_fsm_busy  out  1  refill in progress for that cache.
- ic_write_data_array, dc_write_data_array  out  1  write one returned word.
- ic_write_tag_array, dc_write_tag_array  out  1  write tag/valid, end of refill.
- fill_address  out  16  block base | (word index << 1), shared by both caches.
- fill_data  out  16  mem_data_out passthrough, shared by both caches.
- mem_enable  out  1  memory request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory address.
- mem_data_in  out  16  store data to memory.
- mem_data_out  in  16  read data from memory.
- mem_data_valid  in  1  read data valid.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, counters = 0, last_grant = IC, mask = 0.
  - All outputs 0.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE arbitration, in this order:
  - dc_wr first: drive mem_enable=1, mem_wr=1, mem_addr=dc_addr, mem_data_in=dc_wdata and pulse dc_wr_ack, all combinational in that cycle. Stay in IDLE.
  - Otherwise a miss: if both are requesting, the cache not in last_grant wins; if one, it wins.
  - On a miss grant: latch owner, base = addr & 16'hFFF0, update last_grant, go to FILL next cycle.
  - A request that loses arbitration, or is blocked by a store, holds its line until granted.
- FILL:
  - issue_cnt 0..7 sends one read per cycle: mem_enable=1, mem_wr=0, mem_addr = base | (issue_cnt<<1).
  - Move to DRAIN after issue_cnt = 7.
- Returned words (FILL and DRAIN):
  - Each mem_data_valid asserts owner_write_data_array in the same cycle.
  - fill_address = base | (rcv_cnt<<1) and fill_data = mem_data_out.
  - rcv_cnt increments.
- DRAIN → DONE when the 8th valid is seen (rcv_cnt = 7 with valid).
- DONE:
  - owner_write_tag_array = 1 for one cycle; fill_address = base.
  - Then IDLE, with mask = owner for exactly one cycle: that cache's miss is ignored while it settles.
- owner_fsm_busy = 1 in FILL, DRAIN and DONE. It rises the cycle after grant and falls entering IDLE.
- Timing with grant at cycle t:
  - reads issued t+1..t+8;
  - data at t+5..t+12;
  - tag strobe at t+13;
  - IDLE at t+14.
- Stores during a refill wait, with no ack, until IDLE. Stores are never overlapped with a refill.
- mem_data_valid seen in IDLE is ignored; this covers data still in flight after a reset mid-refill.
- rcv_cnt and issue_cnt are 3 bits and wrap only on a state change.
- The non-owner cache's strobes and fsm_busy stay 0 throughout.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, FILL=2'd1, DRAIN=2'd2, DONE=2'd3;
  - owner encoding: IC=1'b0, DC=1'b1;
  - BLOCK_MASK = 16'hFFF0.
- One sub-module, fill_counter: a 3-bit counter with inc/clr that flags the last word. Instantiated twice, for issue and receive.

Test Plan:
- Single refill: ic_miss, ic_addr=0x1234 at t.
  - mem_addr 0x1230,0x1232..0x123E at t+1..t+8.
  - ic_write_data_array pulses at t+5..t+12 with fill_address 0x1230..0x123E.
  - ic_write_tag_array at t+13.
  - All dc_* outputs stay 0.
- Both miss out of reset: ic_miss(0x0040) and dc_miss(0x8000) together.
  - DC is served first (last_grant=IC at reset), then IC.
  - Repeat both: the grant alternates.
  - The served cache's held miss is not re-granted in the cycle after DONE.
- Store during refill: dc_wr (0x2002, 0xBEEF) raised at t+3 of an IC refill.
  - dc_wr_ack stays 0 until t+14.
  - At t+14: mem_wr=1, mem_addr=0x2002, mem_data_in=0xBEEF.
- Store and miss together in IDLE: dc_wr(0x0010, 0x1111) and ic_miss(0x0100).
  - Store is issued and acked that cycle.
  - The IC refill is granted the next cycle; its first read follows one cycle after that.
- Reset mid-refill: rst low at t+7.
  - All outputs 0 immediately.
  - Memory still raising mem_data_valid during t+8..t+12 causes no write_data_array.
  - A new dc_miss after reset refills correctly.
- Back-to-back refills: dc_miss 0xFFFE, then ic_miss.
  - base = 0xFFF0, last read at 0xFFFE with no overflow.
  - Second refill is granted in the IDLE cycle after DONE.
